decoder: RTL and testbench

- Parameterized N-to-2^N binary-to-one-hot decoder used for select and strobe generation in the CDC synchronizer datapath.
- Combinational one-hot output y follows input a with zero latency.
- A clocked capture stage provides a registered copy of the decode, a valid flag and a change-detect pulse for consumers in the clk domain.

---
 rtl/decoder.sv | 66 ++++++
 tb/tb_decoder.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decoder.sv
// Binary-to-one-hot decoder with a clocked capture stage.
// Define DECODER_CAPTURE_CNT_EN to add the saturating capture counter cnt_q.
module decoder #(
  parameter int N     = 3,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [N-1:0]      a,
  output logic [2**N-1:0]   y,
  output logic [2**N-1:0]   y_q,
  output logic [N-1:0]      a_q,
  output logic              valid_q,
`ifdef DECODER_CAPTURE_CNT_EN
  output logic              chg_q,
  output logic [CNT_W-1:0]  cnt_q
`else
  output logic              chg_q
`endif
);

  localparam int W = 2**N;

  function automatic logic [W-1:0] onehot(
    input logic [N-1:0] c
  );
    logic [W-1:0] r;
    r    = '0;
    r[c] = 1'b1;
    return r;
  endfunction

  always_comb begin
    y = onehot(a);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q     <= '0;
      a_q     <= '0;
      valid_q <= 1'b0;
      chg_q   <= 1'b0;
    end else begin
      chg_q <= 1'b0;
      if (en) begin
        a_q     <= a;
        y_q     <= onehot(a);
        valid_q <= 1'b1;
        // only compare against a code that was really captured
        chg_q   <= valid_q && (a != a_q);
      end
    end
  end

`ifdef DECODER_CAPTURE_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (en && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_decoder.sv
// Directed self-checking bench for decoder.
// Covers N=3 (main), N=1 and N=4 decode widths.
`timescale 1ns/1ps
module tb_decoder;

  logic       clk;
  logic       rst;
  logic       en;
  logic [2:0] a;
  logic [7:0] y;
  logic [7:0] y_q;
  logic [2:0] a_q;
  logic       valid_q;
  logic       chg_q;
`ifdef DECODER_CAPTURE_CNT_EN
  logic [1:0] cnt_q;
`endif

  logic [0:0]  a1;
  logic [1:0]  y1;
  logic [1:0]  y_q1;
  logic [0:0]  a_q1;
  logic        valid_q1;
  logic        chg_q1;
`ifdef DECODER_CAPTURE_CNT_EN
  logic [7:0]  cnt_q1;
`endif

  logic [3:0]  a4;
  logic [15:0] y4;
  logic [15:0] y_q4;
  logic [3:0]  a_q4;
  logic        valid_q4;
  logic        chg_q4;
`ifdef DECODER_CAPTURE_CNT_EN
  logic [7:0]  cnt_q4;
`endif

  int tests;
  int fails;

  decoder #(.N(3), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .en(en),
    .a(a), .y(y), .y_q(y_q), .a_q(a_q),
    .valid_q(valid_q),
`ifdef DECODER_CAPTURE_CNT_EN
    .chg_q(chg_q), .cnt_q(cnt_q)
`else
    .chg_q(chg_q)
`endif
  );

  decoder #(.N(1)) dut1 (
    .clk(clk), .rst(rst), .en(1'b0),
    .a(a1), .y(y1), .y_q(y_q1), .a_q(a_q1),
    .valid_q(valid_q1),
`ifdef DECODER_CAPTURE_CNT_EN
    .chg_q(chg_q1), .cnt_q(cnt_q1)
`else
    .chg_q(chg_q1)
`endif
  );

  decoder #(.N(4)) dut4 (
    .clk(clk), .rst(rst), .en(1'b0),
    .a(a4), .y(y4), .y_q(y_q4), .a_q(a_q4),
    .valid_q(valid_q4),
`ifdef DECODER_CAPTURE_CNT_EN
    .chg_q(chg_q4), .cnt_q(cnt_q4)
`else
    .chg_q(chg_q4)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_comb();
    logic [7:0] exp;
    for (int i = 0; i < 8; i++) begin
      a = 3'(i);
      #5;
      exp = 8'd1 << i;
      tests++;
      if (y !== exp || !$onehot(y)) begin
        fails++;
        $display("FAIL comb a=%0d y=%b exp=%b", i, y, exp);
      end
    end
  endtask

  task automatic test_reset();
    tests++;
    if (y_q !== 8'h00 || a_q !== 3'd0 ||
        valid_q !== 1'b0 || chg_q !== 1'b0) begin
      fails++;
      $display("FAIL reset_init y_q=%b a_q=%0d v=%b c=%b exp=0",
               y_q, a_q, valid_q, chg_q);
    end
    rst = 1'b0;
    en  = 1'b1;
    a   = 3'd5;
    step();
    tests++;
    if (a_q !== 3'd5 || y_q !== 8'h20 || valid_q !== 1'b1) begin
      fails++;
      $display("FAIL cap5 a_q=%0d y_q=%b v=%b exp 5/00100000/1",
               a_q, y_q, valid_q);
    end
    #2;
    rst = 1'b1;
    #1;
    tests++;
    if (y_q !== 8'h00 || a_q !== 3'd0 ||
        valid_q !== 1'b0 || chg_q !== 1'b0) begin
      fails++;
      $display("FAIL async_rst y_q=%b a_q=%0d v=%b c=%b exp=0",
               y_q, a_q, valid_q, chg_q);
    end
    tests++;
    if (y !== 8'h20) begin
      fails++;
      $display("FAIL rst_comb y=%b exp=00100000", y);
    end
    step();
    tests++;
    if (valid_q !== 1'b0 || a_q !== 3'd0) begin
      fails++;
      $display("FAIL rst_hold v=%b a_q=%0d exp 0/0", valid_q, a_q);
    end
  endtask

  task automatic test_capture();
    rst = 1'b0;
    en  = 1'b1;
    a   = 3'd3;
    step();
    tests++;
    if (valid_q !== 1'b1 || y_q !== 8'h08 ||
        chg_q !== 1'b0 || a_q !== 3'd3) begin
      fails++;
      $display("FAIL cap1 v=%b y_q=%b c=%b a_q=%0d exp 1/00001000/0/3",
               valid_q, y_q, chg_q, a_q);
    end
    step();
    tests++;
    if (chg_q !== 1'b0) begin
      fails++;
      $display("FAIL cap2 chg=%b exp=0", chg_q);
    end
    a = 3'd6;
    step();
    tests++;
    if (chg_q !== 1'b1 || y_q !== 8'h40) begin
      fails++;
      $display("FAIL cap3 chg=%b y_q=%b exp 1/01000000",
               chg_q, y_q);
    end
  endtask

  task automatic test_hold();
    logic [7:0] exp;
    en = 1'b0;
    for (int i = 1; i < 8; i++) begin
      a = 3'(i);
      step();
      exp = 8'd1 << i;
      tests++;
      if (y_q !== 8'h40 || a_q !== 3'd6 ||
          chg_q !== 1'b0 || y !== exp) begin
        fails++;
        $display("FAIL hold a=%0d y_q=%b a_q=%0d c=%b y=%b",
                 i, y_q, a_q, chg_q, y);
      end
    end
  endtask

  task automatic test_back_to_back();
    en = 1'b1;
    a  = 3'd1;
    step();
    tests++;
    if (chg_q !== 1'b1 || y_q !== 8'h02) begin
      fails++;
      $display("FAIL b2b1 chg=%b y_q=%b exp 1/00000010",
               chg_q, y_q);
    end
    a = 3'd7;
    step();
    tests++;
    if (chg_q !== 1'b1 || y_q !== 8'h80 || a_q !== 3'd7) begin
      fails++;
      $display("FAIL b2b2 chg=%b y_q=%b a_q=%0d exp 1/10000000/7",
               chg_q, y_q, a_q);
    end
    en = 1'b0;
    step();
    tests++;
    if (chg_q !== 1'b0 || y_q !== 8'h80) begin
      fails++;
      $display("FAIL b2b3 chg=%b y_q=%b exp 0/10000000",
               chg_q, y_q);
    end
  endtask

`ifdef DECODER_CAPTURE_CNT_EN
  task automatic test_counter();
    logic [1:0] exp [5];
    exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    rst = 1'b1;
    #1;
    tests++;
    if (cnt_q !== 2'd0) begin
      fails++;
      $display("FAIL cnt_rst cnt=%0d exp=0", cnt_q);
    end
    rst = 1'b0;
    en  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      tests++;
      if (cnt_q !== exp[i]) begin
        fails++;
        $display("FAIL cnt%0d cnt=%0d exp=%0d", i, cnt_q, exp[i]);
      end
    end
    en  = 1'b0;
    rst = 1'b1;
    #1;
    tests++;
    if (cnt_q !== 2'd0) begin
      fails++;
      $display("FAIL cnt_rst2 cnt=%0d exp=0", cnt_q);
    end
    rst = 1'b0;
  endtask
`endif

  task automatic test_width();
    logic [15:0] exp;
    for (int i = 0; i < 2; i++) begin
      a1 = 1'(i);
      #1;
      tests++;
      if (y1 !== 2'(2'd1 << i)) begin
        fails++;
        $display("FAIL n1 a=%0d y=%b", i, y1);
      end
    end
    for (int i = 0; i < 16; i++) begin
      a4 = 4'(i);
      #1;
      exp = 16'd1 << i;
      tests++;
      if (y4 !== exp) begin
        fails++;
        $display("FAIL n4 a=%0d y=%h exp=%h", i, y4, exp);
      end
    end
    a4 = 4'hf;
    #1;
    tests++;
    if (y4 !== 16'h8000) begin
      fails++;
      $display("FAIL n4_max y=%h exp=8000", y4);
    end
    tests++;
    if (valid_q1 !== 1'b0 || valid_q4 !== 1'b0 ||
        y_q1 !== 2'd0 || y_q4 !== 16'd0 ||
        a_q1 !== 1'b0 || a_q4 !== 4'd0 ||
        chg_q1 !== 1'b0 || chg_q4 !== 1'b0) begin
      fails++;
      $display("FAIL nw_idle v1=%b v4=%b y_q4=%h",
               valid_q1, valid_q4, y_q4);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst   = 1'b1;
    en    = 1'b0;
    a     = '0;
    a1    = '0;
    a4    = '0;
    #2;
    test_comb();
    test_reset();
    test_capture();
    test_hold();
    test_back_to_back();
`ifdef DECODER_CAPTURE_CNT_EN
    test_counter();
`endif
    test_width();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
